// File: rtl/checker_arbiter_pkg.sv
// Shared constants for the two-requester checker arbiter: FSM encoding,
// default counter width and ASCII values used around the checker.
package checker_arbiter_pkg;

    localparam int LEN_W_DEFAULT = 16;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

endpackage

// File: rtl/checker_arbiter_rr_pick.sv
// Two-way round-robin pick: the preferred side wins a tie, a lone
// requester wins regardless of preference.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant
);

    always_comb begin
        if (req[0] && req[1]) begin
            grant = prio;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/checker_arbiter.sv
// Shares one streaming checker between two requesters, one whole message
// at a time, reporting verdict and byte count with a per-side done pulse.
module checker_arbiter
    import checker_arbiter_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       rq_valid,
    input  logic [1:0][7:0]  rq_char,
    input  logic [1:0]       rq_last,
    output logic [1:0]       rq_ready,
    output logic             chk_clear,
    output logic             chk_valid,
    output logic [7:0]       chk_char,
    input  logic             chk_result,
    output logic [1:0]       done,
    output logic             result,
    output logic [LEN_W-1:0] msg_len,
    output logic [2:0]       dbg_state
);

    logic [2:0]       state;
    logic             g;
    logic             prio;
    logic             result_q;
    logic [LEN_W-1:0] cnt;
    logic             pick;
    logic             accept;

    rr_pick2 u_pick (
        .req   (rq_valid),
        .prio  (prio),
        .grant (pick)
    );

    // Handshake: a byte moves when rq_valid[i] & rq_ready[i]; ready is only
    // ever offered to the granted side while streaming.
    assign accept = (state == ST_STREAM) && rq_valid[g];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            g        <= 1'b0;
            prio     <= 1'b0;
            result_q <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|rq_valid) begin
                        g     <= pick;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt   <= '0;
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (cnt != '1) begin
                            cnt <= cnt + LEN_W'(1);
                        end
                        if (rq_last[g]) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    result_q <= chk_result;
                    state    <= ST_REPORT;
                end
                ST_REPORT: begin
                    prio  <= ~g;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rq_ready  = 2'b00;
        done      = 2'b00;
        chk_clear = (state == ST_CLEAR);
        chk_valid = accept;
        chk_char  = accept ? rq_char[g] : ASCII_NUL;
        result    = 1'b0;
        msg_len   = '0;
        if (state == ST_STREAM) begin
            rq_ready[g] = 1'b1;
        end
        // Verdict and count are only presented alongside the done pulse.
        if (state == ST_REPORT) begin
            done[g] = 1'b1;
            result  = result_q;
            msg_len = cnt;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_checker_arbiter.sv
// Directed bench for checker_arbiter: single messages, contention,
// gaps, mid-message reset and a narrow-counter saturation build.
module tb_checker_arbiter;
    import checker_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      rq_valid;
    logic [1:0][7:0] rq_char;
    logic [1:0]      rq_last;
    logic [1:0]      rq_ready;
    logic            chk_clear, chk_valid, chk_result;
    logic [7:0]      chk_char;
    logic [1:0]      done;
    logic            result;
    logic [15:0]     msg_len;
    logic [2:0]      dbg_state;

    logic [1:0]      rq_valid_s;
    logic [1:0][7:0] rq_char_s;
    logic [1:0]      rq_last_s;
    logic [1:0]      rq_ready_s;
    logic            chk_clear_s, chk_valid_s;
    logic [7:0]      chk_char_s;
    logic [1:0]      done_s;
    logic            result_s;
    logic [3:0]      msg_len_s;
    logic [2:0]      dbg_state_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    checker_arbiter dut (
        .clk(clk), .reset(reset),
        .rq_valid(rq_valid), .rq_char(rq_char), .rq_last(rq_last),
        .rq_ready(rq_ready), .chk_clear(chk_clear), .chk_valid(chk_valid),
        .chk_char(chk_char), .chk_result(chk_result), .done(done),
        .result(result), .msg_len(msg_len), .dbg_state(dbg_state)
    );

    checker_arbiter #(.LEN_W(4)) dut_s (
        .clk(clk), .reset(reset),
        .rq_valid(rq_valid_s), .rq_char(rq_char_s), .rq_last(rq_last_s),
        .rq_ready(rq_ready_s), .chk_clear(chk_clear_s), .chk_valid(chk_valid_s),
        .chk_char(chk_char_s), .chk_result(1'b0), .done(done_s),
        .result(result_s), .msg_len(msg_len_s), .dbg_state(dbg_state_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {rq_ready, chk_clear, chk_valid, chk_char, done, result, msg_len}, 32'd0);
    endtask

    // Drives one message from 'side' starting in IDLE. hold_other keeps the
    // opposite side requesting; gap_at inserts a 3-cycle valid gap before that
    // byte; abort_at asserts reset in place of that byte.
    task automatic run_msg(input int side, input string msg, input logic res,
                           input logic hold_other, input int gap_at, input int abort_at);
        int n;
        int oth;
        n   = msg.len();
        oth = 1 - side;
        chk_result = res;
        rq_valid[side] = 1'b1;
        rq_char[side]  = msg[0];
        rq_last[side]  = (n == 1);
        rq_valid[oth]  = hold_other;
        rq_char[oth]   = 8'h3F;
        rq_last[oth]   = 1'b0;
        #1;
        chk("idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        chk("idle_ready", {30'd0, rq_ready}, 32'd0);
        tick();
        chk("clear_pulse", {chk_clear, chk_valid, rq_ready, chk_char}, {1'b1, 1'b0, 2'b00, 8'h00});
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int k = 0; k < 3; k++) begin
                    rq_valid[side] = 1'b0;
                    #1;
                    chk("gap", {chk_valid, chk_char, dbg_state}, {1'b0, 8'h00, ST_STREAM});
                    tick();
                end
            end
            rq_valid[side] = 1'b1;
            rq_char[side]  = msg[i];
            rq_last[side]  = (i == n - 1);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk_all_zero("abort_outputs");
                chk("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
                tick();
                reset    = 1'b0;
                rq_valid = 2'b00;
                rq_last  = 2'b00;
                tick();
                tick();
                chk("abort_no_done", {done, dbg_state}, {2'b00, ST_IDLE});
                return;
            end
            #1;
            chk("stream", {rq_ready, chk_valid, chk_char}, {2'(1 << side), 1'b1, msg[i]});
            tick();
        end
        rq_valid[side] = 1'b0;
        rq_last[side]  = 1'b0;
        #1;
        chk("wait", {dbg_state, chk_valid, chk_char, done}, {ST_WAIT, 1'b0, 8'h00, 2'b00});
        tick();
        chk("report", {done, result, msg_len}, {2'(1 << side), res, 16'(n)});
        tick();
        chk("back_idle", {dbg_state, done, result, msg_len}, {ST_IDLE, 2'b00, 1'b0, 16'd0});
    endtask

    initial begin
        rq_valid   = 2'b00;
        rq_char    = '0;
        rq_last    = 2'b00;
        chk_result = 1'b0;
        rq_valid_s = 2'b00;
        rq_char_s  = '0;
        rq_last_s  = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        tick();
        reset = 1'b0;
        #1;
        chk_all_zero("post_reset_outputs");
        tick();

        // Ten-byte message ending on a space, passing verdict
        run_msg(0, "BEGIN END ", 1'b1, 1'b0, -1, -1);

        // Fresh reset, then both sides contending: strict alternation 0,1,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_msg(0, "abc", 1'b1, 1'b1, -1, -1);
        run_msg(1, "def", 1'b0, 1'b1, -1, -1);
        run_msg(0, "ghi", 1'b1, 1'b1, -1, -1);
        rq_valid = 2'b00;
        tick();

        // Single-byte message from requester 1
        run_msg(1, "x", 1'b0, 1'b0, -1, -1);

        // Three-cycle gap before the third byte; count only accepted bytes
        run_msg(0, "HELLO", 1'b1, 1'b0, 2, -1);

        // Reset on the 4th byte; priority was at req1 beforehand
        run_msg(0, "ABCDEF", 1'b1, 1'b0, -1, 3);
        run_msg(0, "pq", 1'b1, 1'b1, -1, -1);
        run_msg(1, "rs", 1'b0, 1'b0, -1, -1);
        rq_valid = 2'b00;
        tick();

        // Narrow counter saturates at 4'hF over a 20-byte message
        rq_valid_s   = 2'b01;
        rq_char_s[0] = ASCII_SPACE;
        rq_last_s    = 2'b00;
        tick();
        chk("s_clear", {chk_clear_s, chk_valid_s}, {1'b1, 1'b0});
        tick();
        for (int i = 0; i < 20; i++) begin
            rq_char_s[0] = 8'h41 + 8'(i);
            rq_last_s[0] = (i == 19);
            #1;
            chk("s_stream", {rq_ready_s, chk_valid_s, chk_char_s, dbg_state_s},
                {2'b01, 1'b1, 8'h41 + 8'(i), ST_STREAM});
            tick();
        end
        rq_valid_s = 2'b00;
        rq_last_s  = 2'b00;
        tick();
        chk("s_report", {done_s, result_s, msg_len_s}, {2'b01, 1'b0, 4'hF});
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
